// File: rtl/p405s_timer_ctrl.sv
// p405s_timer_ctrl
// Time base lower (TBL) and programmable interval timer (PIT) control.
// An external timebase tick is synchronized into the core clock domain.
// Each synchronized tick advances TBL and, while the PIT is running,
// counts the PIT down. When the PIT expires it raises the TSR PIT status.

module p405s_timer_ctrl (
   input  logic        CB,
   input  logic        rst,
   input  logic        timerClk,
   input  logic        freezeTimers,
   input  logic        PCL_mtSPR,
   input  logic        PCL_sprHold,
   input  logic        tblDcd,
   input  logic        pitDcd,
   input  logic        tsrClrDcd,
   input  logic [0:31] EXE_sprDataBus,
   input  logic        tcrAre,
   input  logic        tcrPie,
   output logic [0:31] tblL2,
   output logic [0:31] pitL2,
   output logic        tbhCIn,
   output logic        freezeTimersNEG,
   output logic        tsrPis,
   output logic        pitIrq,
   output logic        pitRun
);

   typedef enum logic {
      PIT_IDLE = 1'b0,
      PIT_RUN  = 1'b1
   } pit_state_t;

   pit_state_t  pit_state;
   logic [0:31] pit_reload;

   logic sync1;
   logic sync2;
   logic sync3;

   logic tick_pulse;
   logic tick_en;
   logic wr;
   logic tbl_wr;
   logic pit_wr;
   logic tsr_clr;
   logic tbl_all_ones;
   logic pit_at_one;
   logic pit_expire;

   // Bring timerClk into the CB domain and keep one extra stage for edge detection
   always_ff @(posedge CB) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= timerClk;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // A tick that arrives while frozen is simply lost, never held for later
   assign tick_pulse = sync2 & ~sync3;
   assign tick_en    = tick_pulse & ~freezeTimers;

   // A held pipe stage must not let an mtspr touch any timer state
   assign wr      = PCL_mtSPR & ~PCL_sprHold;
   assign tbl_wr  = wr & tblDcd;
   assign pit_wr  = wr & pitDcd;
   assign tsr_clr = wr & tsrClrDcd & EXE_sprDataBus[4];

   assign tbl_all_ones = (tblL2 == 32'hFFFF_FFFF);
   assign pit_at_one   = (pitL2 == 32'd1);

   // Expiry only counts when no PIT write competes in the same cycle
   assign pit_expire = (pit_state == PIT_RUN) & tick_en & pit_at_one & ~pit_wr;

   // Carry into TBU in the same cycle TBL rolls over to zero
   assign tbhCIn = tick_en & tbl_all_ones & ~tbl_wr;

   // Interrupt request is only a mask of the status; masking never clears status
   assign pitIrq = tsrPis & tcrPie;

   // Time base lower: software load has priority over the tick increment
   always_ff @(posedge CB) begin
      if (rst) begin
         tblL2 <= 32'd0;
      end else if (tbl_wr) begin
         tblL2 <= EXE_sprDataBus;
      end else if (tick_en) begin
         tblL2 <= tblL2 + 32'd1;
      end
   end

   // Registered inverse of the debug freeze for downstream timer logic
   always_ff @(posedge CB) begin
      if (rst) begin
         freezeTimersNEG <= 1'b1;
      end else begin
         freezeTimersNEG <= ~freezeTimers;
      end
   end

   // PIT countdown state machine with its count, reload value and status
   always_ff @(posedge CB) begin
      if (rst) begin
         pit_state  <= PIT_IDLE;
         pitRun     <= 1'b0;
         pitL2      <= 32'd0;
         pit_reload <= 32'd0;
         tsrPis     <= 1'b0;
      end else begin
         if (pit_wr) begin
            pitL2      <= EXE_sprDataBus;
            pit_reload <= EXE_sprDataBus;
            if (EXE_sprDataBus != 32'd0) begin
               pit_state <= PIT_RUN;
               pitRun    <= 1'b1;
            end else begin
               pit_state <= PIT_IDLE;
               pitRun    <= 1'b0;
            end
         end else begin
            case (pit_state)
               PIT_RUN: begin
                  if (tick_en) begin
                     if (pit_at_one) begin
                        if (tcrAre) begin
                           pitL2 <= pit_reload;
                        end else begin
                           pitL2     <= 32'd0;
                           pit_state <= PIT_IDLE;
                           pitRun    <= 1'b0;
                        end
                     end else if (pitL2 == 32'd0) begin
                        pit_state <= PIT_IDLE;
                        pitRun    <= 1'b0;
                     end else begin
                        pitL2 <= pitL2 - 32'd1;
                     end
                  end
               end
               default: begin
                  pit_state <= PIT_IDLE;
                  pitRun    <= 1'b0;
               end
            endcase
         end

         if (pit_expire) begin
            tsrPis <= 1'b1;
         end else if (tsr_clr) begin
            tsrPis <= 1'b0;
         end
      end
   end

endmodule
